// File: rtl/fpvec_checker.sv
// fpvec_checker: reads test vectors {vld, op1, op2, yexp, fexp} from a
// synchronous-read memory and drives them into an FP datapath, one vector per
// cycle. Each result is compared LAT cycles later, and the checker keeps
// vec/err counters and records the first failure.
// Build option: define FPVEC_FLAGCHK_EN to also compare res_flags against fexp.
module fpvec_checker #(
   parameter int WIDTH = 64,
   parameter int FLAGW = 5,
   parameter int DEPTH = 50001,
   parameter int LAT   = 1,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int VW   = 1 + 3*WIDTH + FLAGW
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       rm_cfg,
   input  logic             stop_on_err,
   output logic [AW-1:0]    vec_addr,
   input  logic [VW-1:0]    vec_data,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] op2,
   output logic [2:0]       rm,
   output logic             op_valid,
   input  logic [WIDTH-1:0] res,
   input  logic [FLAGW-1:0] res_flags,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [31:0]      vec_count,
   output logic [15:0]      err_count,
   output logic [31:0]      first_err_idx,
   output logic [WIDTH-1:0] first_err_res
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   // A single-entry memory is treated as holding no test vectors.
   localparam bit HAS_VECS = (DEPTH > 1);

   logic             v_vld;
   logic [WIDTH-1:0] v_op1, v_op2, v_yexp;
   logic [FLAGW-1:0] v_fexp;
   assign {v_vld, v_op1, v_op2, v_yexp, v_fexp} = vec_data;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [AW-1:0]    rd_idx_q, rd_idx_d;
   logic             rd_vld_q, rd_vld_d;
   logic [2:0]       rm_q, rm_d;
   logic             stop_q, stop_d;
   logic [31:0]      vec_count_q, vec_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [31:0]      first_err_idx_q, first_err_idx_d;
   logic [WIDTH-1:0] first_err_res_q, first_err_res_d;

   logic [LAT-1:0]            vld_pipe_q, vld_pipe_d;
   logic [LAT-1:0][WIDTH-1:0] y_pipe_q, y_pipe_d;
   logic [LAT-1:0][AW-1:0]    idx_pipe_q, idx_pipe_d;
`ifdef FPVEC_FLAGCHK_EN
   logic [LAT-1:0][FLAGW-1:0] f_pipe_q, f_pipe_d;
`else
   logic unused_flags;
   assign unused_flags = ^{v_fexp, res_flags};
`endif

   logic cmp_vld, mism, stop_now, issue, end_run, start_ok;

   // Compare stage, issue decision and end-of-run detection.
   always_comb begin
      cmp_vld  = vld_pipe_q[LAT-1];
`ifdef FPVEC_FLAGCHK_EN
      mism     = cmp_vld & ((res != y_pipe_q[LAT-1]) | (res_flags != f_pipe_q[LAT-1]));
`else
      mism     = cmp_vld & (res != y_pipe_q[LAT-1]);
`endif
      // stop_on_err suppresses the vector arriving in the mismatch cycle
      stop_now = (state_q == S_RUN) & stop_q & mism;
      issue    = (state_q == S_RUN) & rd_vld_q & v_vld & ~stop_now & HAS_VECS;
      end_run  = (state_q == S_RUN) &
                 (stop_now | (rd_vld_q & (~v_vld | (rd_idx_q == LAST_ADDR))));
      start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
   end

   // Expected-value pipeline: stage LAT-1 lines up with the DUT result.
   always_comb begin
      vld_pipe_d[0] = issue;
      y_pipe_d[0]   = v_yexp;
      idx_pipe_d[0] = rd_idx_q;
`ifdef FPVEC_FLAGCHK_EN
      f_pipe_d[0]   = v_fexp;
`endif
      for (int i = 1; i < LAT; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         y_pipe_d[i]   = y_pipe_q[i-1];
         idx_pipe_d[i] = idx_pipe_q[i-1];
`ifdef FPVEC_FLAGCHK_EN
         f_pipe_d[i]   = f_pipe_q[i-1];
`endif
      end
   end

   // Run control: state, address walk and read-return tracking.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_vld_d = 1'b0;
      rd_idx_d = rd_idx_q;
      rm_d     = rm_q;
      stop_d   = stop_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               addr_d  = '0;
               rm_d    = rm_cfg;
               stop_d  = stop_on_err;
            end
         end
         S_RUN: begin
            if (end_run) begin
               state_d = S_DRAIN;
            end else begin
               // address presented now returns on vec_data next cycle
               rd_vld_d = 1'b1;
               rd_idx_d = addr_q;
               if (addr_q != LAST_ADDR) addr_d = addr_q + AW'(1);
            end
         end
         S_DRAIN: begin
            if (vld_pipe_d == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Result statistics; a new run clears them as it enters RUN.
   always_comb begin
      vec_count_d     = vec_count_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      first_err_res_d = first_err_res_q;
      if (start_ok) begin
         vec_count_d     = '0;
         err_count_d     = '0;
         first_err_idx_d = '1;
         first_err_res_d = '0;
      end else if (cmp_vld) begin
         vec_count_d = vec_count_q + 32'd1;
         if (mism) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) begin
               first_err_idx_d = 32'(idx_pipe_q[LAT-1]);
               first_err_res_d = res;
            end
         end
      end
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         rd_idx_q        <= '0;
         rd_vld_q        <= 1'b0;
         rm_q            <= '0;
         stop_q          <= 1'b0;
         vld_pipe_q      <= '0;
         vec_count_q     <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= '1;
         first_err_res_q <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rd_idx_q        <= rd_idx_d;
         rd_vld_q        <= rd_vld_d;
         rm_q            <= rm_d;
         stop_q          <= stop_d;
         vld_pipe_q      <= vld_pipe_d;
         vec_count_q     <= vec_count_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_res_q <= first_err_res_d;
      end
   end

   // Pipeline payload; only meaningful where the matching valid is set.
   always_ff @(posedge clk) begin
      y_pipe_q   <= y_pipe_d;
      idx_pipe_q <= idx_pipe_d;
`ifdef FPVEC_FLAGCHK_EN
      f_pipe_q   <= f_pipe_d;
`endif
   end

   assign vec_addr      = addr_q;
   assign op_valid      = issue;
   assign op1           = issue ? v_op1 : '0;
   assign op2           = issue ? v_op2 : '0;
   assign rm            = issue ? rm_q : 3'b000;
   assign busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
   assign done          = (state_q == S_DONE);
   assign pass          = done & (err_count_q == 16'd0);
   assign vec_count     = vec_count_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_res = first_err_res_q;

endmodule

// File: tb/tb_fpvec_checker.sv
// Bench for fpvec_checker: two instances (LAT=3 deep memory, LAT=1 DEPTH=8),
// vector memories generated from a hash of the address, a toy pipelined
// datapath as the unit under test, and a run-level reference model.
`timescale 1ns/1ps
module tb_fpvec_checker;
   localparam int W  = 16;
   localparam int FW = 5;
   localparam int VW = 1 + 3*W + FW;
   localparam int DA = 70002;
   localparam int LA = 3;
   localparam int DB = 8;
   localparam int LB = 1;
   localparam int AWA = $clog2(DA);
   localparam int AWB = $clog2(DB);
`ifdef FPVEC_FLAGCHK_EN
   localparam bit FLAGCHK = 1'b1;
`else
   localparam bit FLAGCHK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int tests = 0;
   int fails = 0;

   // run configuration seen by both vector memories
   int          nvec;
   bit          cfg_stop;
   logic [2:0]  cfg_rm;
   logic [31:0] seed;
   bit          allbad;
   bit          ybad [256];
   bit          fbad [256];

   // model expectations for the current run
   int          exp_issued, exp_err;
   logic [31:0] exp_fidx;
   logic [W-1:0] exp_fres;
   int          iss;

   // instance A signals
   logic a_start, a_ov, a_busy, a_done, a_pass;
   logic [AWA-1:0] a_addr;
   logic [VW-1:0]  a_vd;
   logic [W-1:0]   a_op1, a_op2, a_res, a_fres;
   logic [2:0]     a_rm;
   logic [FW-1:0]  a_flg;
   logic [31:0]    a_vc, a_fidx;
   logic [15:0]    a_ec;
   // instance B signals
   logic b_start, b_ov, b_busy, b_done, b_pass;
   logic [AWB-1:0] b_addr;
   logic [VW-1:0]  b_vd;
   logic [W-1:0]   b_op1, b_op2, b_res, b_fres;
   logic [2:0]     b_rm;
   logic [FW-1:0]  b_flg;
   logic [31:0]    b_vc, b_fidx;
   logic [15:0]    b_ec;

   fpvec_checker #(.WIDTH(W), .FLAGW(FW), .DEPTH(DA), .LAT(LA)) u_a (
      .clk(clk), .reset_n(rst_n), .start(a_start), .rm_cfg(cfg_rm), .stop_on_err(cfg_stop),
      .vec_addr(a_addr), .vec_data(a_vd), .op1(a_op1), .op2(a_op2), .rm(a_rm), .op_valid(a_ov),
      .res(a_res), .res_flags(a_flg), .busy(a_busy), .done(a_done), .pass(a_pass),
      .vec_count(a_vc), .err_count(a_ec), .first_err_idx(a_fidx), .first_err_res(a_fres));

   fpvec_checker #(.WIDTH(W), .FLAGW(FW), .DEPTH(DB), .LAT(LB)) u_b (
      .clk(clk), .reset_n(rst_n), .start(b_start), .rm_cfg(cfg_rm), .stop_on_err(cfg_stop),
      .vec_addr(b_addr), .vec_data(b_vd), .op1(b_op1), .op2(b_op2), .rm(b_rm), .op_valid(b_ov),
      .res(b_res), .res_flags(b_flg), .busy(b_busy), .done(b_done), .pass(b_pass),
      .vec_count(b_vc), .err_count(b_ec), .first_err_idx(b_fidx), .first_err_res(b_fres));

   function automatic logic [W-1:0] hsh(int i, int k);
      logic [31:0] x;
      x = seed ^ (32'(i) * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B);
      x = x ^ (x >> 15);
      x = x * 32'h2C1B3C6D;
      x = x ^ (x >> 13);
      return x[W-1:0];
   endfunction

   // toy datapath under test: result and flags
   function automatic logic [W-1:0] fu(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] r);
      return x + y + {13'd0, r};
   endfunction
   function automatic logic [FW-1:0] fl(logic [W-1:0] x, logic [W-1:0] y);
      return x[4:0] ^ y[15:11];
   endfunction

   function automatic bit ybad_at(int i);
      return allbad || (i >= 0 && i < 256 && ybad[i]);
   endfunction
   function automatic bit fbad_at(int i);
      return i >= 0 && i < 256 && fbad[i];
   endfunction
   function automatic bit err_at(int i);
      return ybad_at(i) || (FLAGCHK && fbad_at(i));
   endfunction

   function automatic logic [VW-1:0] mem_word(int i);
      logic [W-1:0] x, y, ye;
      logic [FW-1:0] fe;
      x  = hsh(i, 0);
      y  = hsh(i, 1);
      ye = fu(x, y, cfg_rm) ^ (ybad_at(i) ? 16'h0100 : 16'h0000);
      fe = fl(x, y) ^ (fbad_at(i) ? 5'h01 : 5'h00);
      return {1'(i < nvec), x, y, ye, fe};
   endfunction

   // synchronous-read memories and the LAT-deep datapaths
   logic [W-1:0]  a_rp [LA];
   logic [FW-1:0] a_fp [LA];
   logic [W-1:0]  b_rp;
   logic [FW-1:0] b_fp;
   always @(posedge clk) begin
      a_vd <= mem_word(int'(a_addr));
      b_vd <= mem_word(int'(b_addr));
      a_rp[0] <= fu(a_op1, a_op2, a_rm);
      a_fp[0] <= fl(a_op1, a_op2);
      for (int i = 1; i < LA; i++) begin
         a_rp[i] <= a_rp[i-1];
         a_fp[i] <= a_fp[i-1];
      end
      b_rp <= fu(b_op1, b_op2, b_rm);
      b_fp <= fl(b_op1, b_op2);
   end
   assign a_res = a_rp[LA-1];
   assign a_flg = a_fp[LA-1];
   assign b_res = b_rp;
   assign b_flg = b_fp;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Run-level reference: which vectors get issued and what the counters end at.
   task automatic model(input int depth, input int lat);
      int n, first, cnt;
      n = (depth <= 1) ? 0 : ((nvec < depth) ? nvec : depth);
      first = -1;
      for (int i = 0; i < n && first < 0; i++) if (err_at(i)) first = i;
      exp_issued = (cfg_stop && first >= 0 && first + lat < n) ? first + lat : n;
      cnt = 0;
      for (int i = 0; i < exp_issued; i++) if (err_at(i)) cnt++;
      exp_err  = (cnt > 65535) ? 65535 : cnt;
      exp_fidx = (first >= 0) ? 32'(first) : 32'hFFFF_FFFF;
      exp_fres = (first >= 0) ? fu(hsh(first, 0), hsh(first, 1), cfg_rm) : '0;
   endtask

   task automatic chk_issue(input string nm, input logic [W-1:0] o1, input logic [W-1:0] o2,
                            input logic [2:0] r);
      chk({nm, "_iss_in_range"}, 64'(iss < exp_issued), 64'd1);
      chk({nm, "_op1"}, 64'(o1), 64'(hsh(iss, 0)));
      chk({nm, "_op2"}, 64'(o2), 64'(hsh(iss, 1)));
      chk({nm, "_rm"}, 64'(r), 64'(cfg_rm));
      iss++;
   endtask

   // every issue cycle: operands in address order, run's rounding mode, within bound
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_ov) chk_issue("a", a_op1, a_op2, a_rm);
         if (b_ov) chk_issue("b", b_op1, b_op2, b_rm);
      end
   end

   task automatic final_chk(input string nm, input logic dn, input logic bsy, input logic ps,
                            input logic [31:0] vc, input logic [15:0] ec,
                            input logic [31:0] fi, input logic [W-1:0] fr);
      chk({nm, "_done"}, 64'(dn), 64'd1);
      chk({nm, "_busy"}, 64'(bsy), 64'd0);
      chk({nm, "_vec_count"}, 64'(vc), 64'(exp_issued));
      chk({nm, "_err_count"}, 64'(ec), 64'(exp_err));
      chk({nm, "_first_err_idx"}, 64'(fi), 64'(exp_fidx));
      chk({nm, "_first_err_res"}, 64'(fr), 64'(exp_fres));
      chk({nm, "_pass"}, 64'(ps), 64'(exp_err == 0));
      chk({nm, "_issued"}, 64'(iss), 64'(exp_issued));
   endtask

   task automatic clear_tbl();
      allbad = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ybad[i] = 1'b0;
         fbad[i] = 1'b0;
      end
   endtask

   task automatic run(input bit on_b, input int n, input bit stop, input logic [2:0] r);
      int lim;
      nvec = n; cfg_stop = stop; cfg_rm = r;
      model(on_b ? DB : DA, on_b ? LB : LA);
      iss = 0;
      @(negedge clk);
      if (on_b) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      lim = exp_issued + 40;
      for (int c = 0; c < lim && !(on_b ? b_done : a_done); c++) @(negedge clk);
      if (on_b) final_chk("b", b_done, b_busy, b_pass, b_vc, b_ec, b_fidx, b_fres);
      else      final_chk("a", a_done, a_busy, a_pass, a_vc, a_ec, a_fidx, a_fres);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_busy"}, 64'(a_busy), 64'd0);
      chk({nm, "_done"}, 64'(a_done), 64'd0);
      chk({nm, "_pass"}, 64'(a_pass), 64'd0);
      chk({nm, "_vec_count"}, 64'(a_vc), 64'd0);
      chk({nm, "_err_count"}, 64'(a_ec), 64'd0);
      chk({nm, "_first_err_idx"}, 64'(a_fidx), 64'hFFFF_FFFF);
      chk({nm, "_first_err_res"}, 64'(a_fres), 64'd0);
      chk({nm, "_op_valid"}, 64'(a_ov), 64'd0);
      chk({nm, "_vec_addr"}, 64'(a_addr), 64'd0);
      chk({nm, "_op1"}, 64'(a_op1), 64'd0);
      chk({nm, "_rm"}, 64'(a_rm), 64'd0);
      chk({nm, "_b_busy"}, 64'(b_busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
      nvec = 0; cfg_stop = 1'b0; cfg_rm = 3'd0; seed = 32'h1234_5678; iss = 0;
      clear_tbl();
      repeat (3) @(negedge clk);
      chk_reset_state("rst");
      rst_n = 1'b1;

      // LAT=1, four good vectors, terminator at address 4, rm=1
      clear_tbl();
      run(1'b1, 4, 1'b0, 3'b001);
      chk("lat1_vec_count", 64'(b_vc), 64'd4);
      chk("lat1_err_count", 64'(b_ec), 64'd0);
      chk("lat1_pass", 64'(b_pass), 64'd1);

      // LAT=3, ten vectors with indices 2 and 7 wrong
      clear_tbl(); ybad[2] = 1'b1; ybad[7] = 1'b1;
      run(1'b0, 10, 1'b0, 3'($urandom_range(0, 7)));
      chk("two_err_count", 64'(a_ec), 64'd2);
      chk("two_err_first_idx", 64'(a_fidx), 64'd2);
      chk("two_err_pass", 64'(a_pass), 64'd0);

      // halt on first error at index 5: 5 good + 3 in flight compared
      clear_tbl(); ybad[5] = 1'b1;
      run(1'b0, 20, 1'b1, 3'd2);
      chk("stop_vec_count", 64'(a_vc), 64'd8);
      chk("stop_err_count", 64'(a_ec), 64'd1);

      // flag-only mismatch at index 0
      clear_tbl(); fbad[0] = 1'b1;
      run(1'b0, 6, 1'b0, 3'd0);
      chk("flag_err_count", 64'(a_ec), 64'(FLAGCHK));

      // immediate terminator at address 0
      clear_tbl();
      run(1'b0, 0, 1'b0, 3'd3);
      chk("empty_vec_count", 64'(a_vc), 64'd0);
      chk("empty_pass", 64'(a_pass), 64'd1);

      // randomized runs on both instances
      for (int t = 0; t < 12; t++) begin
         clear_tbl();
         seed = $urandom;
         for (int i = 0; i < 64; i++) begin
            ybad[i] = ($urandom_range(0, 11) == 0);
            fbad[i] = ($urandom_range(0, 11) == 0);
         end
         run((t % 2) == 1, $urandom_range(0, 60), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)));
      end

      // DEPTH=8 memory full of valid vectors stops after address 7
      clear_tbl();
      run(1'b1, 20, 1'b0, 3'd5);
      chk("depth_vec_count", 64'(b_vc), 64'd8);

      // reset pulse while index 20 is in flight, then a clean rerun
      clear_tbl();
      nvec = 40; cfg_stop = 1'b0; cfg_rm = 3'd6;
      model(DA, LA);
      iss = 0;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      for (int c = 0; c < 100 && iss < 21; c++) @(negedge clk);
      chk("midrun_reached_idx20", 64'(iss >= 21), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_state("midrun_rst");
      run(1'b0, 30, 1'b0, 3'd6);
      chk("rerun_vec_count", 64'(a_vc), 64'd30);

      // every vector wrong: error counter saturates
      clear_tbl(); allbad = 1'b1;
      run(1'b0, 70000, 1'b0, 3'd0);
      chk("sat_err_count", 64'(a_ec), 64'h0000_FFFF);
      chk("sat_vec_count", 64'(a_vc), 64'd70000);
      chk("sat_first_idx", 64'(a_fidx), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
